// File: rtl/fetch_sequencer.sv
// Purpose: instruction fetch sequencer. It drives pcNext for an external PC register, reads imem over req/ack, and offers the word to decode over valid/ready.
// Latency: the fetch request starts in the cycle after the PC settles. Data reaches decode one cycle after imem_ack. Best case is one instruction every 2 cycles.
// Backpressure: the PC is held (pcNext = pc) while memory stalls or decode deasserts instr_ready. Redirects never withdraw an issued request.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pc / pcNext               current PC from / next PC to the external PC register
//   imem_req/addr/ack/rdata   instruction memory read handshake
//   instr/instr_pc/valid/ready   decode handshake
//   branch_taken/target       single-cycle redirect request
//   misalign_err              registered pulse: redirect target was not word aligned
//   fetch_count               instructions accepted by decode (wraps)
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned STEP         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pcNext,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] STEP_INC = 32'(STEP);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] drain_addr;

    logic capture;      // memory word accepted into the decode slot
    logic consume;      // decode took the word
    logic start_drain;  // redirect while a fetch is still outstanding

    assign capture     = (state == S_FETCH) && imem_ack && !branch_taken;
    assign consume     = (state == S_VALID) && instr_ready && !branch_taken;
    assign start_drain = (state == S_FETCH) && branch_taken && !imem_ack;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: begin
                // A redirect with data in hand just drops the word. Without data, the
                // request in flight must be completed in S_DRAIN.
                if (branch_taken) begin
                    state_nxt = imem_ack ? S_FETCH : S_DRAIN;
                end else if (imem_ack) begin
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (branch_taken || instr_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        pcNext      = pc;
        imem_req    = 1'b0;
        imem_addr   = pc;
        instr_valid = 1'b0;
        case (state)
            S_BOOT:  pcNext = RESET_VECTOR;
            S_FETCH: imem_req = 1'b1;
            S_VALID: begin
                instr_valid = !branch_taken;
                if (instr_ready && !branch_taken) begin
                    pcNext = pc + STEP_INC;
                end
            end
            S_DRAIN: begin
                // The PC already points at the redirect target, so the address of
                // the stale request comes from drain_addr.
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: pcNext = RESET_VECTOR;
        endcase
        if (state != S_BOOT && branch_taken) begin
            pcNext = {branch_target[31:2], 2'b00};
        end
        // The PC register must load the reset vector on the edge seen during reset.
        if (rst) begin
            pcNext      = RESET_VECTOR;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr        <= 32'h0;
            instr_pc     <= 32'h0;
            fetch_count  <= 32'h0;
            misalign_err <= 1'b0;
            drain_addr   <= 32'h0;
        end else begin
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (consume) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (start_drain) begin
                drain_addr <= pc;
            end
            misalign_err <= (state != S_BOOT) && branch_taken && (branch_target[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: exercises fetch_sequencer against a flag-based reference model, using a latency-controlled memory and a PC register.
// Latency: every cycle is compared at the falling edge. Directed phases pin literal values.
// Backpressure: instr_ready and memory wait states are randomized. Resets are injected mid-run.
module tb_fetch_sequencer;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        misalign_err;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    // The external PC register.
    always @(posedge clk) pc <= pcNext;

    fetch_sequencer #(.RESET_VECTOR(RV), .STEP(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pcNext(pcNext),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model. A fetch is pending whenever booted and not holding; stale marks a redirected, still-outstanding read.
    bit          booted, holding, stale, m_mis;
    logic [31:0] m_instr, m_ipc, m_drain, m_count;

    // Stimulus controls.
    bit          cur_br, cur_ready, force_ack, in_req;
    logic [31:0] cur_tgt;
    int          fixed_lat = -1;
    int          lat;
    logic [31:0] q_pc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive this cycle's inputs, then compare all outputs at the falling edge.
    task automatic half1();
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_pcn;
        branch_taken  = cur_br;
        branch_target = cur_tgt;
        instr_ready   = cur_ready;
        if (imem_req === 1'b1) begin
            if (!in_req) begin
                in_req = 1'b1;
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (lat == 0) begin
                imem_ack = 1'b1;
            end else begin
                imem_ack = 1'b0;
                lat--;
            end
        end else begin
            imem_ack = force_ack;
        end
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
        @(negedge clk);
        e_req   = booted && !holding;
        e_addr  = stale ? m_drain : pc;
        e_valid = booted && holding && !cur_br;
        if (!booted)                    e_pcn = RV;
        else if (cur_br)                e_pcn = {cur_tgt[31:2], 2'b00};
        else if (holding && cur_ready)  e_pcn = pc + STEP;
        else                            e_pcn = pc;
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
        chk("pcNext", pcNext, e_pcn);
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("fetch_count", fetch_count, m_count);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    // Advance the model with this cycle's inputs, then move past the rising edge.
    task automatic half2();
        if (!booted) begin
            booted = 1'b1;
            m_mis  = 1'b0;
        end else begin
            m_mis = cur_br && (cur_tgt[1:0] != 2'b00);
            if (stale) begin
                if (imem_ack) stale = 1'b0;
            end else if (holding) begin
                if (cur_br) begin
                    holding = 1'b0;
                end else if (cur_ready) begin
                    holding = 1'b0;
                    m_count = m_count + 32'd1;
                end
            end else begin
                if (cur_br) begin
                    if (!imem_ack) begin
                        stale   = 1'b1;
                        m_drain = pc;
                    end
                end else if (imem_ack) begin
                    holding = 1'b1;
                    m_instr = mem_word(pc);
                    m_ipc   = pc;
                end
            end
        end
        if (imem_req === 1'b1 && imem_ack) in_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        half1();
        half2();
    endtask

    // Assert reset asynchronously, check the cleared outputs, then hold reset over one edge.
    task automatic do_reset();
        rst          = 1'b1;
        in_req       = 1'b0;
        lat          = 0;
        force_ack    = 1'b0;
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        cur_br       = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_pcNext", pcNext, RV);
        booted = 0; holding = 0; stale = 0; m_mis = 0;
        m_instr = 0; m_ipc = 0; m_drain = 0; m_count = 0;
        @(posedge clk);
        #1;
        chk("rst_pc", pc, RV);
        rst = 1'b0;
    endtask

    initial begin
        cur_ready = 1'b1;
        cur_tgt   = 32'h0;
        #1;
        // Zero-wait memory with decode always ready.
        do_reset();
        fixed_lat = 0;
        for (int i = 0; i < 9; i++) begin
            half1();
            if (instr_valid === 1'b1) q_pc.push_back(instr_pc);
            half2();
        end
        chk("p1_count", fetch_count, 32'd4);
        chk("p1_nvalid", q_pc.size(), 32'd4);
        for (int i = 0; i < 4 && i < q_pc.size(); i++) chk("p1_instr_pc", q_pc[i], 32'(i * 4));

        // Three memory wait states on the fetch at 0x4.
        do_reset();
        fixed_lat = 0;
        for (int i = 0; i < 3; i++) cycle();
        fixed_lat = 3;
        for (int i = 0; i < 4; i++) begin
            half1();
            chk("p2_req", {31'd0, imem_req}, 32'd1);
            chk("p2_addr", imem_addr, 32'h4);
            chk("p2_pcNext", pcNext, 32'h4);
            chk("p2_pc", pc, 32'h4);
            half2();
        end
        // Decode stalls for 5 cycles.
        cur_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            half1();
            chk("p3_instr", instr, 32'hA5A5_0004);
            chk("p3_instr_pc", instr_pc, 32'h4);
            chk("p3_pc", pc, 32'h4);
            chk("p3_count", fetch_count, 32'd1);
            chk("p3_valid", {31'd0, instr_valid}, 32'd1);
            half2();
        end
        cur_ready = 1'b1;
        half1();
        chk("p3_pcNext", pcNext, 32'h8);
        half2();
        chk("p3_count_adv", fetch_count, 32'd2);

        // Redirect to 0x100 while the fetch at 0x8 is stalled.
        fixed_lat = 3;
        cur_br = 1'b1; cur_tgt = 32'h100;
        half1();
        chk("p4_pcNext", pcNext, 32'h100);
        chk("p4_addr", imem_addr, 32'h8);
        half2();
        cur_br = 1'b0; fixed_lat = 0;
        for (int i = 0; i < 3; i++) begin
            half1();
            chk("p4_drain_pc", pc, 32'h100);
            chk("p4_drain_addr", imem_addr, 32'h8);
            chk("p4_drain_req", {31'd0, imem_req}, 32'd1);
            half2();
        end
        half1();
        chk("p4_new_addr", imem_addr, 32'h100);
        chk("p4_discard", instr, 32'hA5A5_0004);
        half2();
        // Misaligned redirect to 0x102 while decode is taking the word.
        cur_br = 1'b1; cur_tgt = 32'h102;
        half1();
        chk("p5_valid", {31'd0, instr_valid}, 32'd0);
        chk("p5_pcNext", pcNext, 32'h100);
        chk("p5_instr", instr, 32'hA5A5_0100);
        half2();
        chk("p5_count", fetch_count, 32'd2);
        chk("p5_mis", {31'd0, misalign_err}, 32'd1);
        // Redirect to the top of the address space, then wrap past it.
        cur_tgt = 32'hFFFF_FFFC;
        half1();
        chk("p6_pcNext", pcNext, 32'hFFFF_FFFC);
        half2();
        cur_br = 1'b0;
        chk("p5_mis_clear", {31'd0, misalign_err}, 32'd0);
        half1();
        chk("p6_addr", imem_addr, 32'hFFFF_FFFC);
        half2();
        half1();
        chk("p6_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("p6_wrap", pcNext, 32'h0);
        half2();
        chk("p6_pc", pc, 32'h0);

        // Reset while draining, then a late ack in boot.
        fixed_lat = 3;
        cur_br = 1'b1; cur_tgt = 32'h200;
        cycle();
        cur_br = 1'b0;
        half1();
        chk("p7_drain_addr", imem_addr, 32'h0);
        chk("p7_pc", pc, 32'h200);
        #2;
        do_reset();
        force_ack = 1'b1; cur_br = 1'b1; cur_tgt = 32'h300;
        cycle();
        force_ack = 1'b0; cur_br = 1'b0;
        half1();
        chk("p7_boot_ack", instr, 32'h0);
        chk("p7_fetch_addr", imem_addr, RV);
        half2();

        // Randomized traffic with occasional resets.
        fixed_lat = -1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cur_ready = ($urandom_range(0, 3) != 0);
            cur_br    = !cur_br && ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       cur_tgt = 32'hFFFF_FFFC;
                1:       cur_tgt = $urandom() & 32'h0000_0FFC;
                default: cur_tgt = $urandom();
            endcase
            cycle();
            if (i % 700 == 699) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
